// File: rtl/pipeline_mem_responder_pkg.sv
// rtl/pipeline_mem_responder_pkg.sv - Memory map constants and decode helper for the memory responder
package pipeline_mem_responder_pkg;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFFF0;

    typedef enum logic [3:0] {
        MMIO_CONSOLE_TX = 4'h0,
        MMIO_STATUS     = 4'h1,
        MMIO_CYC_LO     = 4'h2,
        MMIO_CYC_HI     = 4'h3
    } mmio_reg_e;

    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;

    // The MMIO window is one 16-word page; only the page number is compared.
    function automatic logic in_mmio(input logic [15:0] addr, input logic [11:0] page);
        return addr[15:4] == page;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - Byte FIFO feeding the console stream; accepts a push into a full FIFO when a pop lands on the same edge
module console_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pipeline_mem_responder.sv
// rtl/pipeline_mem_responder.sv - Dual-read/single-write word RAM with write-first bypass, MMIO console FIFO, status and cycle counter
module pipeline_mem_responder
    import pipeline_mem_responder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_en,
    input  logic [15:0] mem_read0_addr,
    output logic [15:0] mem_read0_data,
    input  logic [15:0] mem_read1_addr,
    output logic [15:0] mem_read1_data,
    input  logic        mem_write_en,
    input  logic [15:0] mem_write_addr,
    input  logic [15:0] mem_write_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam logic [11:0] MMIO_PAGE = MMIO_BASE[15:4];

    logic [15:0] ram [0:65535];

    logic [15:0] rd_addr   [2];
    logic [15:0] rd_word   [2];
    logic [15:0] rd_data_q [2];
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] cyc_hi_q, cyc_hi_d;
    logic        ovf_q, ovf_d;
    logic [15:0] status_word;
    logic        wr_mmio, wr_ram, push_req, clr_ovf, pop, cyc_lo_hit;
    logic        fifo_full, fifo_empty;

    assign rd_addr[0]     = mem_read0_addr;
    assign rd_addr[1]     = mem_read1_addr;
    assign mem_read0_data = rd_data_q[0];
    assign mem_read1_data = rd_data_q[1];

    assign wr_mmio  = mem_write_en && in_mmio(mem_write_addr, MMIO_PAGE);
    assign wr_ram   = mem_write_en && !in_mmio(mem_write_addr, MMIO_PAGE);
    assign push_req = wr_mmio && (mem_write_addr[3:0] == MMIO_CONSOLE_TX);
    assign clr_ovf  = wr_mmio && (mem_write_addr[3:0] == MMIO_STATUS);
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;

    console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_req),
        .push_data_i (mem_write_data[7:0]),
        .pop_i       (pop),
        .head_o      (tx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        status_word                      = '0;
        status_word[STATUS_EMPTY_BIT]    = fifo_empty;
        status_word[STATUS_FULL_BIT]     = fifo_full;
        status_word[STATUS_OVERFLOW_BIT] = ovf_q;
    end

    // MMIO reads see pre-edge register state; RAM reads see a same-edge write.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = '0;
            if (in_mmio(rd_addr[p], MMIO_PAGE)) begin
                case (rd_addr[p][3:0])
                    MMIO_STATUS: rd_word[p] = status_word;
                    MMIO_CYC_LO: rd_word[p] = cyc_q[15:0];
                    MMIO_CYC_HI: rd_word[p] = cyc_hi_q;
                    default:     rd_word[p] = '0;
                endcase
            end else if (wr_ram && (mem_write_addr == rd_addr[p])) begin
                rd_word[p] = mem_write_data;
            end else begin
                rd_word[p] = ram[rd_addr[p]];
            end
        end
    end

    always_comb begin
        cyc_lo_hit = mem_read_en &&
                     ((in_mmio(mem_read0_addr, MMIO_PAGE) && (mem_read0_addr[3:0] == MMIO_CYC_LO)) ||
                      (in_mmio(mem_read1_addr, MMIO_PAGE) && (mem_read1_addr[3:0] == MMIO_CYC_LO)));
        cyc_d    = cyc_q + 32'd1;
        cyc_hi_d = cyc_lo_hit ? cyc_q[31:16] : cyc_hi_q;
        ovf_d    = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push_req && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            cyc_q        <= '0;
            cyc_hi_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            if (mem_read_en) begin
                rd_data_q[0] <= rd_word[0];
                rd_data_q[1] <= rd_word[1];
            end
            cyc_q    <= cyc_d;
            cyc_hi_q <= cyc_hi_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[mem_write_addr] <= mem_write_data;
        end
    end

endmodule

// File: tb/tb_pipeline_mem_responder.sv
// tb/tb_pipeline_mem_responder.sv - Self-checking bench for pipeline_mem_responder
module tb_pipeline_mem_responder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_en = 1'b0;
    logic [15:0] mem_read0_addr = '0;
    logic [15:0] mem_read0_data;
    logic [15:0] mem_read1_addr = '0;
    logic [15:0] mem_read1_data;
    logic        mem_write_en = 1'b0;
    logic [15:0] mem_write_addr = '0;
    logic [15:0] mem_write_data = '0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  fifo_m [$];
    logic        ovf_m = 1'b0;
    logic [31:0] cyc_model = '0;
    logic [31:0] cyc_seen = '0;

    always #5 clk = ~clk;

    pipeline_mem_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_en    (mem_read_en),
        .mem_read0_addr (mem_read0_addr),
        .mem_read0_data (mem_read0_data),
        .mem_read1_addr (mem_read1_addr),
        .mem_read1_data (mem_read1_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready)
    );

    // Counter value observed by a read on each edge = edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_model = '0;
            cyc_seen  = '0;
        end else begin
            cyc_seen  = cyc_model;
            cyc_model = cyc_model + 32'd1;
        end
    end

    function automatic logic [15:0] status_m();
        return {13'b0, ovf_m, fifo_m.size() == DEPTH, fifo_m.size() == 0};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mem_write_en   = 1'b1;
        mem_write_addr = a;
        mem_write_data = d;
        mem_read_en    = 1'b0;
        step();
        mem_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a0, input logic [15:0] a1);
        mem_read_en    = 1'b1;
        mem_read0_addr = a0;
        mem_read1_addr = a1;
        step();
        mem_read_en    = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr(16'hFFF0, {8'hA5, b});
        if (fifo_m.size() < DEPTH) fifo_m.push_back(b);
        else ovf_m = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (mem_read0_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd0: got %h want 0000", mem_read0_data); end
        n_cmp++; if (mem_read1_data !== 16'h0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0000", mem_read1_data); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        rst_n = 1'b1;
        rd(16'hFFF1, 16'hFFF2);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL reset_status: got %h want %h", mem_read0_data, status_m()); end
        n_cmp++; if (mem_read1_data !== cyc_seen[15:0]) begin n_fail++; $display("FAIL reset_cyc_lo: got %h want %h", mem_read1_data, cyc_seen[15:0]); end
    endtask

    task automatic test_read_hold();
        wr(16'h0010, 16'hBEEF);
        wr(16'h0011, 16'h1111);
        rd(16'h0010, 16'h0010);
        n_cmp++; if (mem_read0_data !== 16'hBEEF) begin n_fail++; $display("FAIL read0: got %h want BEEF", mem_read0_data); end
        n_cmp++; if (mem_read1_data !== 16'hBEEF) begin n_fail++; $display("FAIL read1: got %h want BEEF", mem_read1_data); end
        mem_read_en    = 1'b0;
        mem_read0_addr = 16'h0011;
        mem_read1_addr = 16'h0011;
        step();
        n_cmp++; if (mem_read0_data !== 16'hBEEF) begin n_fail++; $display("FAIL hold0: got %h want BEEF", mem_read0_data); end
        n_cmp++; if (mem_read1_data !== 16'hBEEF) begin n_fail++; $display("FAIL hold1: got %h want BEEF", mem_read1_data); end
    endtask

    task automatic test_bypass();
        wr(16'h0020, 16'hAAAA);
        mem_write_en = 1'b1; mem_write_addr = 16'h0020; mem_write_data = 16'h1234;
        mem_read_en = 1'b1; mem_read0_addr = 16'h0010; mem_read1_addr = 16'h0020;
        step();
        mem_write_en = 1'b0; mem_read_en = 1'b0;
        n_cmp++; if (mem_read1_data !== 16'h1234) begin n_fail++; $display("FAIL bypass1: got %h want 1234", mem_read1_data); end
        n_cmp++; if (mem_read0_data !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_other0: got %h want BEEF", mem_read0_data); end
        mem_write_en = 1'b1; mem_write_addr = 16'h0021; mem_write_data = 16'h5678;
        mem_read_en = 1'b1; mem_read0_addr = 16'h0021; mem_read1_addr = 16'h0020;
        step();
        mem_write_en = 1'b0; mem_read_en = 1'b0;
        n_cmp++; if (mem_read0_data !== 16'h5678) begin n_fail++; $display("FAIL bypass0: got %h want 5678", mem_read0_data); end
        n_cmp++; if (mem_read1_data !== 16'h1234) begin n_fail++; $display("FAIL stored1: got %h want 1234", mem_read1_data); end
    endtask

    task automatic test_fifo_overflow();
        tx_ready = 1'b0;
        push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
        rd(16'hFFF1, 16'hFFF4);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_3: got %h want %h", mem_read0_data, status_m()); end
        n_cmp++; if (mem_read1_data !== 16'h0) begin n_fail++; $display("FAIL unmapped: got %h want 0000", mem_read1_data); end
        push_byte(8'h44);
        rd(16'hFFF1, 16'hFFF0);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_full: got %h want %h", mem_read0_data, status_m()); end
        n_cmp++; if (mem_read1_data !== 16'h0) begin n_fail++; $display("FAIL console_rd: got %h want 0000", mem_read1_data); end
        push_byte(8'h45);
        rd(16'hFFF1, 16'hFFF1);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_ovf: got %h want %h", mem_read0_data, status_m()); end
        tx_ready = 1'b1;
        while (fifo_m.size() > 0) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== fifo_m[0]) begin n_fail++; $display("FAIL drain_a: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, fifo_m[0]); end
            step();
            void'(fifo_m.pop_front());
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drained_a: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
        rd(16'hFFF1, 16'hFFF1);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_drain: got %h want %h", mem_read0_data, status_m()); end
        wr(16'hFFF1, 16'h0000);
        ovf_m = 1'b0;
        rd(16'hFFF1, 16'hFFF1);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_clr: got %h want %h", mem_read0_data, status_m()); end
    endtask

    task automatic test_full_push_pop();
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
        mem_write_en = 1'b1; mem_write_addr = 16'hFFF0; mem_write_data = 16'h0055;
        tx_ready = 1'b1;
        n_cmp++; if (tx_data !== fifo_m[0]) begin n_fail++; $display("FAIL full_head: got %h want %h", tx_data, fifo_m[0]); end
        step();
        void'(fifo_m.pop_front());
        fifo_m.push_back(8'h55);
        mem_write_en = 1'b0; tx_ready = 1'b0;
        rd(16'hFFF1, 16'hFFF1);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL status_pushpop: got %h want %h", mem_read0_data, status_m()); end
        tx_ready = 1'b1;
        while (fifo_m.size() > 0) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== fifo_m[0]) begin n_fail++; $display("FAIL drain_b: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, fifo_m[0]); end
            step();
            void'(fifo_m.pop_front());
        end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drained_b: got %b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_random_ram();
        logic [15:0] ram_m [16];
        logic [15:0] a0, a1, wa, wd, exp0, exp1;
        logic        re, we;
        for (int i = 0; i < 16; i++) begin
            ram_m[i] = 16'($urandom);
            wr(16'h0100 + 16'(i), ram_m[i]);
        end
        rd(16'h0100, 16'h0101);
        exp0 = ram_m[0];
        exp1 = ram_m[1];
        for (int n = 0; n < 300; n++) begin
            re = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 1) != 0);
            a0 = ($urandom_range(0, 9) == 0) ? 16'hFFF0 + 16'($urandom_range(4, 15)) : 16'h0100 + 16'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 9) == 0) ? 16'hFFF0 + 16'($urandom_range(4, 15)) : 16'h0100 + 16'($urandom_range(0, 15));
            wa = ($urandom_range(0, 6) == 0) ? 16'hFFF0 + 16'($urandom_range(4, 15)) : 16'h0100 + 16'($urandom_range(0, 15));
            wd = 16'($urandom);
            if (re) begin
                exp0 = (a0 >= 16'hFFF0) ? 16'h0 : ((we && wa == a0) ? wd : ram_m[a0[3:0]]);
                exp1 = (a1 >= 16'hFFF0) ? 16'h0 : ((we && wa == a1) ? wd : ram_m[a1[3:0]]);
            end
            if (we && wa < 16'hFFF0) ram_m[wa[3:0]] = wd;
            mem_read_en = re; mem_read0_addr = a0; mem_read1_addr = a1;
            mem_write_en = we; mem_write_addr = wa; mem_write_data = wd;
            step();
            n_cmp++; if (mem_read0_data !== exp0) begin n_fail++; $display("FAIL rand_rd0 #%0d: got %h want %h", n, mem_read0_data, exp0); end
            n_cmp++; if (mem_read1_data !== exp1) begin n_fail++; $display("FAIL rand_rd1 #%0d: got %h want %h", n, mem_read1_data, exp1); end
        end
        mem_read_en = 1'b0; mem_write_en = 1'b0;
    endtask

    task automatic test_cycle_counter();
        rd(16'hFFF2, 16'hFFF2);
        n_cmp++; if (mem_read0_data !== cyc_seen[15:0]) begin n_fail++; $display("FAIL cyc_lo0: got %h want %h", mem_read0_data, cyc_seen[15:0]); end
        n_cmp++; if (mem_read1_data !== cyc_seen[15:0]) begin n_fail++; $display("FAIL cyc_lo1: got %h want %h", mem_read1_data, cyc_seen[15:0]); end
        rd(16'hFFF3, 16'hFFF1);
        n_cmp++; if (mem_read0_data !== cyc_seen[31:16]) begin n_fail++; $display("FAIL cyc_hi_small: got %h want %h", mem_read0_data, cyc_seen[31:16]); end
        step(); step(); step();
        rd(16'hFFF1, 16'hFFF2);
        n_cmp++; if (mem_read1_data !== cyc_seen[15:0]) begin n_fail++; $display("FAIL cyc_lo_later: got %h want %h", mem_read1_data, cyc_seen[15:0]); end
        force dut.cyc_q = 32'h0001_FFFF;
        rd(16'hFFF2, 16'hFFF5);
        release dut.cyc_q;
        n_cmp++; if (mem_read0_data !== 16'hFFFF) begin n_fail++; $display("FAIL cyc_lo_forced: got %h want FFFF", mem_read0_data); end
        rd(16'hFFF3, 16'hFFF5);
        n_cmp++; if (mem_read0_data !== 16'h0001) begin n_fail++; $display("FAIL cyc_hi_shadow: got %h want 0001", mem_read0_data); end
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        push_byte(8'h61); push_byte(8'h62);
        rd(16'h0010, 16'h0020);
        n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %b want 1", tx_valid); end
        mem_read_en = 1'b1; mem_read0_addr = 16'h0010; mem_read1_addr = 16'h0020;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL async_tx_data: got %h want 00", tx_data); end
        n_cmp++; if (mem_read0_data !== 16'h0) begin n_fail++; $display("FAIL async_rd0: got %h want 0000", mem_read0_data); end
        n_cmp++; if (mem_read1_data !== 16'h0) begin n_fail++; $display("FAIL async_rd1: got %h want 0000", mem_read1_data); end
        fifo_m.delete();
        ovf_m = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_read0_data !== 16'h0) begin n_fail++; $display("FAIL inflight_rd0: got %h want 0000", mem_read0_data); end
        rst_n = 1'b1;
        rd(16'hFFF1, 16'hFFF2);
        n_cmp++; if (mem_read0_data !== status_m()) begin n_fail++; $display("FAIL post_rst_status: got %h want %h", mem_read0_data, status_m()); end
        n_cmp++; if (mem_read1_data !== 16'h0000) begin n_fail++; $display("FAIL post_rst_cyc0: got %h want 0000", mem_read1_data); end
        rd(16'hFFF3, 16'hFFF2);
        n_cmp++; if (mem_read1_data !== cyc_seen[15:0]) begin n_fail++; $display("FAIL post_rst_cyc1: got %h want %h", mem_read1_data, cyc_seen[15:0]); end
        n_cmp++; if (mem_read0_data !== 16'h0000) begin n_fail++; $display("FAIL post_rst_hi: got %h want 0000", mem_read0_data); end
    endtask

    initial begin
        test_reset();
        test_read_hold();
        test_bypass();
        test_fifo_overflow();
        test_full_push_pop();
        test_random_ram();
        test_cycle_counter();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
